// File: rtl/usb_serial_pkg.sv
// Shared defaults for the USB CDC serial datapath.
package usb_serial_pkg;

  localparam int unsigned USB_SERIAL_ASIZE_DEF = 10;
  localparam int unsigned USB_RX_AFULL_GAP_DEF = 64;
  localparam int unsigned USB_RX_DROP_CNT_W    = 16;

  // Pointer pair is full when the addresses match but the wrap bits differ.
  function automatic logic ptr_full(input logic wr_wrap, input logic rd_wrap,
                                    input logic addr_eq);
    return addr_eq && (wr_wrap != rd_wrap);
  endfunction

endpackage

// File: rtl/usb_rx_sdpram.sv
// Simple dual-port byte RAM: synchronous write, registered 1-cycle read.
// The read register only updates on re_i, so it holds a fetched byte until
// the consumer is ready for it.
module usb_rx_sdpram #(
  parameter int unsigned AddrW = 10
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [7:0]       wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [7:0]       rdata_o
);

  localparam int unsigned Depth = 1 << AddrW;

  logic [7:0] mem [Depth];
  logic [7:0] rdata_q;

  // Array write and registered read; no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/usb_serial_rx_buffer.sv
// Host-to-device receive buffer: OUT endpoint 0x01 byte strobes into a RAM
// FIFO, drained through a single registered valid/ready output stage.
// Optional feature macro: USB_RX_DROP_CNT_EN builds the saturating
// dropped-byte counter; otherwise drop_cnt is tied to zero.
module usb_serial_rx_buffer
  import usb_serial_pkg::*;
#(
  parameter int unsigned ASIZE     = USB_SERIAL_ASIZE_DEF,
  parameter int unsigned AFULL_GAP = USB_RX_AFULL_GAP_DEF
) (
  input  logic                         clk,
  input  logic                         usb_rstn,
  input  logic [7:0]                   ep01_data,
  input  logic                         ep01_valid,
  output logic [7:0]                   recv_data,
  output logic                         recv_valid,
  input  logic                         recv_ready,
  output logic [ASIZE:0]               level,
  output logic                         almost_full,
  output logic                         overflow,
  input  logic                         overflow_clr,
  output logic [USB_RX_DROP_CNT_W-1:0] drop_cnt
);

  localparam int unsigned   Depth      = 1 << ASIZE;
  localparam int unsigned   AfullInt   = Depth - AFULL_GAP;
  localparam logic [ASIZE:0] AfullLevel = AfullInt[ASIZE:0];

  logic [ASIZE:0] wptr_q, wptr_d;
  logic [ASIZE:0] rptr_q, rptr_d;
  logic           rd_pend_q, rd_pend_d;
  logic           recv_valid_q, recv_valid_d;
  logic [7:0]     recv_data_q, recv_data_d;
  logic           overflow_q, overflow_d;
  logic [7:0]     ram_rdata;

  logic empty, full, wr_en, drop, rd_issue, load;

  // Status decode from the pre-edge pointers and handshake state.
  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = ptr_full(wptr_q[ASIZE], rptr_q[ASIZE],
                     wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]);
    wr_en = ep01_valid && !full;
    drop  = ep01_valid && full;
    // Pending RAM byte moves into the output register once that slot frees.
    load  = rd_pend_q && (!recv_valid_q || recv_ready);
    // A second fetch behind a pending one is only started while the user is
    // accepting, so a byte never gets stranded behind a stalled output slot.
    rd_issue = !empty && (!recv_valid_q || recv_ready) && (!rd_pend_q || recv_ready);
  end

  // Next-state for pointers, read pipeline, output stage and overflow flag.
  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    rd_pend_d    = rd_pend_q;
    recv_valid_d = recv_valid_q;
    recv_data_d  = recv_data_q;
    overflow_d   = overflow_q;

    if (wr_en) begin
      wptr_d = wptr_q + 1'b1;
    end

    if (rd_issue) begin
      rptr_d    = rptr_q + 1'b1;
      rd_pend_d = 1'b1;
    end else if (load) begin
      rd_pend_d = 1'b0;
    end

    if (load) begin
      recv_valid_d = 1'b1;
      recv_data_d  = ram_rdata;
    end else if (recv_valid_q && recv_ready) begin
      recv_valid_d = 1'b0;
    end

    // Set wins over a same-cycle clear.
    if (overflow_clr) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge usb_rstn) begin
    if (!usb_rstn) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      rd_pend_q    <= 1'b0;
      recv_valid_q <= 1'b0;
      recv_data_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      rd_pend_q    <= rd_pend_d;
      recv_valid_q <= recv_valid_d;
      recv_data_q  <= recv_data_d;
      overflow_q   <= overflow_d;
    end
  end

  usb_rx_sdpram #(
    .AddrW (ASIZE)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wptr_q[ASIZE-1:0]),
    .wdata_i (ep01_data),
    .re_i    (rd_issue),
    .raddr_i (rptr_q[ASIZE-1:0]),
    .rdata_o (ram_rdata)
  );

`ifdef USB_RX_DROP_CNT_EN
  logic [USB_RX_DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating drop counter; a drop in the clearing cycle counts as the first.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && overflow_clr) begin
      drop_cnt_d = USB_RX_DROP_CNT_W'(1);
    end else if (overflow_clr) begin
      drop_cnt_d = '0;
    end else if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge usb_rstn) begin
    if (!usb_rstn) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

  assign level       = wptr_q - rptr_q;
  assign almost_full = (level >= AfullLevel);
  assign recv_data   = recv_data_q;
  assign recv_valid  = recv_valid_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_usb_serial_rx_buffer.sv
// Directed bench for usb_serial_rx_buffer, built with a 16-byte RAM.
module tb_usb_serial_rx_buffer;

  localparam int unsigned ASIZE     = 4;
  localparam int unsigned AFULL_GAP = 4;

`ifdef USB_RX_DROP_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic           clk;
  logic           usb_rstn;
  logic [7:0]     ep01_data;
  logic           ep01_valid;
  logic [7:0]     recv_data;
  logic           recv_valid;
  logic           recv_ready;
  logic [ASIZE:0] level;
  logic           almost_full;
  logic           overflow;
  logic           overflow_clr;
  logic [15:0]    drop_cnt;

  int tests;
  int fails;

  usb_serial_rx_buffer #(
    .ASIZE     (ASIZE),
    .AFULL_GAP (AFULL_GAP)
  ) dut (
    .clk          (clk),
    .usb_rstn     (usb_rstn),
    .ep01_data    (ep01_data),
    .ep01_valid   (ep01_valid),
    .recv_data    (recv_data),
    .recv_valid   (recv_valid),
    .recv_ready   (recv_ready),
    .level        (level),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .drop_cnt     (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           vld;
    logic [7:0]     dat;
    logic           rdy;
    logic           e_valid;
    logic [7:0]     e_data;
    logic [ASIZE:0] e_level;
    logic           e_af;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},  32'(recv_data), 0);
    check({tag, "_valid"}, 32'(recv_valid), 0);
    check({tag, "_level"}, 32'(level), 0);
    check({tag, "_af"},    32'(almost_full), 0);
    check({tag, "_ovf"},   32'(overflow), 0);
    check({tag, "_drops"}, 32'(drop_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            first;
    int            got;
    int            gap;
    int            wr_cnt;
    int            rx_cnt;
    logic          prev_hold;
    logic [7:0]    prev_data;
    logic [7:0]    exp_q[$];
    logic [7:0]    exp_b;

    tests = 0;
    fails = 0;

    // Latency (rows 0-3) then backpressure 0x11/0x22/0x33 (rows 4-12).
    vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 5'd0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[4]  = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0};
    vecs[5]  = '{1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0};
    vecs[6]  = '{1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 5'd2, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 5'd2, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 5'd2, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 5'd0, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 5'd0, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};

    usb_rstn     = 1'b0;
    ep01_data    = '0;
    ep01_valid   = 1'b0;
    recv_ready   = 1'b0;
    overflow_clr = 1'b0;
    #1;
    check_all_zero("reset");
    step();
    step();
    usb_rstn = 1'b1;
    step();

    for (int i = 0; i < 13; i++) begin
      ep01_valid = vecs[i].vld;
      ep01_data  = vecs[i].dat;
      recv_ready = vecs[i].rdy;
      step();
      check($sformatf("vec%0d_valid", i), 32'(recv_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].e_level));
      check($sformatf("vec%0d_af", i), 32'(almost_full), 32'(vecs[i].e_af));
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d_data", i), 32'(recv_data), 32'(vecs[i].e_data));
      end
    end
    ep01_valid = 1'b0;

    // Burst of 64 bytes with recv_ready held high.
    recv_ready = 1'b1;
    first = -1;
    got   = 0;
    gap   = 0;
    for (int i = 0; i < 80; i++) begin
      ep01_valid = (i < 64);
      ep01_data  = 8'(i);
      step();
      if (recv_valid) begin
        if (first < 0) first = i;
        check("burst_data", 32'(recv_data), 32'(got & 8'hFF));
        got++;
      end else if (first >= 0 && got < 64) begin
        gap++;
      end
    end
    ep01_valid = 1'b0;
    check("burst_first", 32'(first), 2);
    check("burst_count", 32'(got), 64);
    check("burst_gaps", 32'(gap), 0);
    check("burst_level", 32'(level), 0);

    // Overflow: 20 bytes into 16 RAM slots plus the output register.
    recv_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ep01_valid = 1'b1;
      ep01_data  = 8'(8'h40 + i);
      step();
      if (i == 11) check("af_below", 32'(almost_full), 0);
      if (i == 12) check("af_at", 32'(almost_full), 1);
      if (i == 16) check("ovf_not_yet", 32'(overflow), 0);
      if (i == 17) check("ovf_set", 32'(overflow), 1);
    end
    ep01_valid = 1'b0;
    step();
    check("ovf_level", 32'(level), 16);
    check("ovf_valid", 32'(recv_valid), 1);
    check("ovf_data", 32'(recv_data), 32'h40);
    check("ovf_af", 32'(almost_full), 1);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_drops", 32'(drop_cnt), CntEn ? 32'd3 : 32'd0);

    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    check("clr_flag", 32'(overflow), 0);
    check("clr_drops", 32'(drop_cnt), 0);

    // Clear and drop in the same cycle: the drop wins.
    ep01_valid   = 1'b1;
    ep01_data    = 8'h99;
    overflow_clr = 1'b1;
    step();
    ep01_valid   = 1'b0;
    overflow_clr = 1'b0;
    check("race_flag", 32'(overflow), 1);
    check("race_drops", 32'(drop_cnt), CntEn ? 32'd1 : 32'd0);
    check("race_level", 32'(level), 16);
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;

    // Drain the 17 held bytes.
    recv_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 60 && got < 17; c++) begin
      if (recv_valid) begin
        check("drain_data", 32'(recv_data), 32'(8'h40 + got));
        got++;
      end
      step();
    end
    step();
    check("drain_count", 32'(got), 17);
    check("drain_level", 32'(level), 0);
    check("drain_valid", 32'(recv_valid), 0);

    // Wrap-around stream with random recv_ready.
    wr_cnt    = 0;
    rx_cnt    = 0;
    prev_hold = 1'b0;
    prev_data = '0;
    recv_ready = 1'b0;
    for (int cyc = 0; cyc < 1500 && rx_cnt < 100; cyc++) begin
      ep01_valid = (wr_cnt < 100) && (cyc % 4 == 0);
      ep01_data  = 8'(wr_cnt * 7 + 3);
      if (ep01_valid) begin
        exp_q.push_back(ep01_data);
        wr_cnt++;
      end
      step();
      if (prev_hold) begin
        check("hold_valid", 32'(recv_valid), 1);
        check("hold_data", 32'(recv_data), 32'(prev_data));
      end
      recv_ready = 1'($urandom_range(0, 1));
      if (recv_valid && recv_ready) begin
        if (exp_q.size() == 0) begin
          check("wrap_extra", 32'(recv_data), 32'hFFFF_FFFF);
        end else begin
          exp_b = exp_q.pop_front();
          check("wrap_order", 32'(recv_data), 32'(exp_b));
        end
        rx_cnt++;
      end
      prev_hold = recv_valid && !recv_ready;
      prev_data = recv_data;
    end
    ep01_valid = 1'b0;
    recv_ready = 1'b1;
    step();
    step();
    check("wrap_count", 32'(rx_cnt), 100);
    check("wrap_ovf", 32'(overflow), 0);
    check("wrap_level", 32'(level), 0);

    // Reset mid-packet with buffered bytes and a sticky overflow.
    recv_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      ep01_valid = 1'b1;
      ep01_data  = 8'(8'h60 + i);
      step();
    end
    check("pre_rst_ovf", 32'(overflow), 1);
    ep01_data = 8'h77;
    usb_rstn  = 1'b0;
    #2;
    check_all_zero("rst_async");
    step();
    check_all_zero("rst_held");
    ep01_valid = 1'b0;
    usb_rstn   = 1'b1;
    recv_ready = 1'b1;
    ep01_valid = 1'b1;
    ep01_data  = 8'h5A;
    step();
    ep01_valid = 1'b0;
    check("post_e0_valid", 32'(recv_valid), 0);
    check("post_e0_level", 32'(level), 1);
    step();
    check("post_e1_valid", 32'(recv_valid), 0);
    step();
    check("post_e2_valid", 32'(recv_valid), 1);
    check("post_e2_data", 32'(recv_data), 32'h5A);
    step();
    check("post_e3_valid", 32'(recv_valid), 0);
    check("post_e3_level", 32'(level), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
